// File: rtl/majority_voter_seq_pkg.sv
// majority_pkg: shared helpers for the registered N-channel majority voter.
//   clog2     - counter width for a given saturation value
//   popcount  - number of set bits in a channel mask (up to 16 channels)
//   params_ok - legality of N / FAULT_LIMIT (N odd, 3..15; FAULT_LIMIT 1..255)
package majority_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic logic [4:0] popcount(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
      return c;
   endfunction

   function automatic bit params_ok(input int n, input int fault_limit);
      return (n >= 3) && (n <= 15) && (n % 2 == 1) &&
             (fault_limit >= 1) && (fault_limit <= 255);
   endfunction

endpackage

// File: rtl/majority_voter_seq_if.sv
// majority_voter_seq_if: handshake/bus bundle of the majority voter.
//   master: in_valid, din[N][W], fault_clr out; voter results in
//   slave : the voter side (dout, out_valid, disagree, fault, tie, no_quorum out)
// Channel i of din is din[i], i.e. bits [i*W +: W] of the flat vector.
interface majority_voter_seq_if #(
   parameter int N = 5,
   parameter int W = 4
);
   logic                  in_valid;
   logic [N-1:0][W-1:0]   din;
   logic                  fault_clr;
   logic [W-1:0]          dout;
   logic                  out_valid;
   logic [N-1:0]          disagree;
   logic [N-1:0]          fault;
   logic                  tie;
   logic                  no_quorum;

   modport master (
      output in_valid, din, fault_clr,
      input  dout, out_valid, disagree, fault, tie, no_quorum
   );

   modport slave (
      input  in_valid, din, fault_clr,
      output dout, out_valid, disagree, fault, tie, no_quorum
   );
endinterface

// File: rtl/majority_voter_seq_fault_ctr.sv
// majority_fault_ctr: one channel's consecutive-disagreement counter and
// sticky fault flag.
//   clk, rst : clock, synchronous active-high reset
//   en       : a vote with quorum happened this cycle
//   mis      : this channel disagreed with that vote
//   clr      : zero counter and flag (wins over an increment/fault set)
//   fault    : sticky flag, set on the edge the count reaches FAULT_LIMIT
module majority_fault_ctr
   import majority_pkg::*;
#(
   parameter int FAULT_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic mis,
   input  logic clr,
   output logic fault
);
   localparam int            CW    = clog2(FAULT_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(FAULT_LIMIT);

   logic [CW-1:0] cnt, cnt_nxt;

   // An agreeing vote restarts the run; a disagreeing one saturates at LIMIT.
   always_comb begin
      cnt_nxt = '0;
      if (mis) cnt_nxt = (cnt == LIMIT) ? cnt : cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt   <= '0;
         fault <= 1'b0;
      end else if (en) begin
         cnt <= cnt_nxt;
         if (cnt_nxt == LIMIT) fault <= 1'b1;
      end
   end
endmodule

// File: rtl/majority_voter_seq.sv
// majority_voter_seq: registered N-channel bitwise majority voter with
// per-channel consecutive-disagreement fault tracking.
//   clk, rst : clock, synchronous active-high reset
//   bus      : majority_voter_seq_if.slave (in_valid, din, fault_clr in;
//              dout, out_valid, disagree, fault, tie, no_quorum out)
// Optional build macro FAULT_MASK_EN: faulted channels drop out of the vote
// and of disagree; tie / no_quorum become live. Without it every channel
// always votes, N is odd so tie and no_quorum are constant 0.
module majority_voter_seq
   import majority_pkg::*;
#(
   parameter int N           = 5,
   parameter int W           = 4,
   parameter int FAULT_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   majority_voter_seq_if.slave     bus
);
   localparam int STAGES = 1;

   if (!params_ok(N, FAULT_LIMIT)) begin : g_bad_params
      $error("majority_voter_seq: N must be odd in 3..15, FAULT_LIMIT in 1..255");
   end

   logic [N-1:0]      active, fault, disagree_c, disagree_q, col;
   logic [4:0]        act_cnt, ones;
   logic [W-1:0]      vote_c, dout_q;
   logic              tie_c, nq_c, tie_q, nq_q, cnt_en;
   logic [STAGES:0]   vld_pipe;

`ifdef FAULT_MASK_EN
   // Mask comes from the registered fault flags, so a new fault only
   // affects votes after its own edge.
   assign active = ~fault;
   assign nq_c   = (act_cnt == 5'd0);
`else
   assign active = '1;
   assign nq_c   = 1'b0;
`endif
   assign act_cnt = popcount(16'(active));

   // Per bit: compare 2*ones with A; an exact split keeps the old dout bit.
   // With A == 0 every bit lands in the split case, so dout holds for free;
   // tie is only reported when there is a quorum.
   always_comb begin
      vote_c = dout_q;
      tie_c  = 1'b0;
      col    = '0;
      ones   = '0;
      for (int b = 0; b < W; b++) begin
         for (int i = 0; i < N; i++) col[i] = bus.din[i][b] & active[i];
         ones = popcount(16'(col));
         if ({ones, 1'b0} > {1'b0, act_cnt})      vote_c[b] = 1'b1;
         else if ({ones, 1'b0} < {1'b0, act_cnt}) vote_c[b] = 1'b0;
         else begin
`ifdef FAULT_MASK_EN
            if (!nq_c) tie_c = 1'b1;
`endif
         end
      end
   end

   always_comb begin
      disagree_c = '0;
      for (int i = 0; i < N; i++)
         disagree_c[i] = active[i] & (bus.din[i] != vote_c);
   end

   // A no-quorum vote leaves the counters untouched.
   assign cnt_en = bus.in_valid & ~nq_c;

   for (genvar i = 0; i < N; i++) begin : g_ch
      majority_fault_ctr #(.FAULT_LIMIT(FAULT_LIMIT)) u_ctr (
         .clk   (clk),
         .rst   (rst),
         .en    (cnt_en),
         .mis   (disagree_c[i]),
         .clr   (bus.fault_clr),
         .fault (fault[i])
      );
   end

   assign vld_pipe[0] = bus.in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe[STAGES:1] <= '0;
         dout_q             <= '0;
         disagree_q         <= '0;
         tie_q              <= 1'b0;
         nq_q               <= 1'b0;
      end else begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         tie_q              <= bus.in_valid & tie_c;
         nq_q               <= bus.in_valid & nq_c;
         if (bus.in_valid) begin
            dout_q     <= vote_c;
            disagree_q <= disagree_c;
         end
      end
   end

   assign bus.dout      = dout_q;
   assign bus.out_valid = vld_pipe[STAGES];
   assign bus.disagree  = disagree_q;
   assign bus.fault     = fault;
   assign bus.tie       = tie_q;
   assign bus.no_quorum = nq_q;
endmodule

// File: tb/tb_majority_voter_seq.sv
// tb_majority_voter_seq: directed scenarios plus a randomized run checked
// against a behavioural model (set arithmetic over the list of voting channels).
// Build with FAULT_MASK_EN defined to also cover tie / no_quorum behaviour.
module tb_majority_voter_seq;
   localparam int N  = 5;
   localparam int W  = 4;
   localparam int FL = 4;
`ifdef FAULT_MASK_EN
   localparam bit MASK = 1'b1;
`else
   localparam bit MASK = 1'b0;
`endif

   typedef logic [N-1:0][W-1:0] din_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   majority_voter_seq_if #(.N(N), .W(W)) bus ();

   majority_voter_seq #(.N(N), .W(W), .FAULT_LIMIT(FL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors = 0;
   int errs    = 0;

   // behavioural model state
   logic [W-1:0] m_dout;
   logic         m_ov, m_tie, m_nq;
   logic [N-1:0] m_dis, m_fault;
   int           m_cnt[N];

   task automatic model_reset();
      m_dout = '0; m_ov = 0; m_tie = 0; m_nq = 0; m_dis = '0; m_fault = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   task automatic model_step(input logic v, input din_t d, input logic clr);
      int act[$];
      int ones;
      logic [W-1:0] vote;
      for (int i = 0; i < N; i++) if (!MASK || !m_fault[i]) act.push_back(i);
      m_ov = v; m_tie = 0; m_nq = 0;
      if (v) begin
         if (act.size() == 0) begin
            m_nq  = 1;
            m_dis = '0;
         end else begin
            vote = m_dout;
            for (int b = 0; b < W; b++) begin
               ones = 0;
               foreach (act[k]) ones += int'(d[act[k]][b]);
               if (2 * ones > act.size())      vote[b] = 1'b1;
               else if (2 * ones < act.size()) vote[b] = 1'b0;
               else                            m_tie   = 1'b1;
            end
            m_dis = '0;
            foreach (act[k]) if (d[act[k]] != vote) m_dis[act[k]] = 1'b1;
            m_dout = vote;
            for (int i = 0; i < N; i++) begin
               if (m_dis[i]) begin
                  m_cnt[i] = (m_cnt[i] < FL) ? m_cnt[i] + 1 : FL;
                  if (m_cnt[i] == FL) m_fault[i] = 1'b1;
               end else m_cnt[i] = 0;
            end
         end
      end
      if (clr) begin
         m_fault = '0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
   endtask

   // Drive one cycle, advance the model, land 1 time unit after the edge.
   task automatic tick(input logic v, input din_t d, input logic clr);
      bus.in_valid  = v;
      bus.din       = d;
      bus.fault_clr = clr;
      if (rst) model_reset();
      else     model_step(v, d, clr);
      @(posedge clk);
      #1;
   endtask

   function automatic din_t mk(input logic [W-1:0] base, input int ch, input logic [W-1:0] odd);
      din_t r;
      for (int i = 0; i < N; i++) r[i] = (i == ch) ? odd : base;
      return r;
   endfunction

   function automatic din_t rnd_din();
      din_t r;
      for (int i = 0; i < N; i++) r[i] = W'($urandom);
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, rnd_din(), 1'b0);
         vectors++;
         if ({bus.dout, bus.out_valid, bus.disagree, bus.fault, bus.tie, bus.no_quorum} !== '0) begin
            errs++;
            $display("FAIL reset_hold got dout=%h ov=%b dis=%b flt=%b tie=%b nq=%b want all 0",
                     bus.dout, bus.out_valid, bus.disagree, bus.fault, bus.tie, bus.no_quorum);
         end
      end
      rst = 1'b0;
      tick(1'b0, rnd_din(), 1'b0);
      vectors++;
      if ({bus.dout, bus.out_valid, bus.disagree, bus.fault, bus.tie, bus.no_quorum} !== '0) begin
         errs++;
         $display("FAIL reset_release got dout=%h ov=%b dis=%b flt=%b want all 0",
                  bus.dout, bus.out_valid, bus.disagree, bus.fault);
      end
   endtask

   task automatic test_basic();
      tick(1'b1, mk(4'hA, 2, 4'h5), 1'b0);
      vectors++;
      if ({bus.dout, bus.out_valid, bus.disagree, bus.tie} !== {4'hA, 1'b1, 5'b00100, 1'b0}) begin
         errs++;
         $display("FAIL basic_vote got dout=%h ov=%b dis=%b tie=%b want A 1 00100 0",
                  bus.dout, bus.out_valid, bus.disagree, bus.tie);
      end
      tick(1'b0, rnd_din(), 1'b0);
      vectors++;
      if ({bus.dout, bus.out_valid, bus.disagree, bus.tie, bus.no_quorum} !== {4'hA, 1'b0, 5'b00100, 1'b0, 1'b0}) begin
         errs++;
         $display("FAIL basic_idle_hold got dout=%h ov=%b dis=%b tie=%b nq=%b want A 0 00100 0 0",
                  bus.dout, bus.out_valid, bus.disagree, bus.tie, bus.no_quorum);
      end
   endtask

   task automatic test_fault();
      logic [N-1:0] exp;
      int pat[7] = '{1, 1, 1, 0, 1, 1, 1};
      tick(1'b1, mk(4'hA, -1, 4'h0), 1'b0);   // agreement restarts ch2's run
      for (int k = 1; k <= FL; k++) begin
         tick(1'b1, mk(4'hA, 2, 4'h5), 1'b0);
         exp = (k == FL) ? 5'b00100 : 5'b00000;
         vectors++;
         if ({bus.fault, bus.disagree} !== {exp, 5'b00100}) begin
            errs++;
            $display("FAIL fault_run%0d got flt=%b dis=%b want %b 00100", k, bus.fault, bus.disagree, exp);
         end
         tick(1'b0, rnd_din(), 1'b0);
         vectors++;
         if ({bus.fault, bus.out_valid} !== {exp, 1'b0}) begin
            errs++;
            $display("FAIL fault_gap%0d got flt=%b ov=%b want %b 0", k, bus.fault, bus.out_valid, exp);
         end
      end
      tick(1'b0, rnd_din(), 1'b1);
      vectors++;
      if (bus.fault !== 5'b0) begin
         errs++;
         $display("FAIL fault_clear got flt=%b want 00000", bus.fault);
      end
      foreach (pat[k]) begin
         tick(1'b1, pat[k] ? mk(4'hA, 2, 4'h5) : mk(4'hA, -1, 4'h0), 1'b0);
         vectors++;
         if (bus.fault !== 5'b0) begin
            errs++;
            $display("FAIL fault_broken_run step%0d got flt=%b want 00000", k, bus.fault);
         end
      end
   endtask

   task automatic test_clr_priority();
      tick(1'b1, mk(4'hA, -1, 4'h0), 1'b0);
      for (int k = 1; k < FL; k++) tick(1'b1, mk(4'hA, 2, 4'h5), 1'b0);
      tick(1'b1, mk(4'hA, 2, 4'h5), 1'b1);
      vectors++;
      if ({bus.fault, bus.dout, bus.disagree} !== {5'b0, 4'hA, 5'b00100}) begin
         errs++;
         $display("FAIL clr_priority got flt=%b dout=%h dis=%b want 00000 A 00100",
                  bus.fault, bus.dout, bus.disagree);
      end
      // counter must have restarted: FL-1 more mismatches stay clean, the FL-th faults
      for (int k = 1; k <= FL; k++) begin
         tick(1'b1, mk(4'hA, 2, 4'h5), 1'b0);
         vectors++;
         if (bus.fault !== ((k == FL) ? 5'b00100 : 5'b00000)) begin
            errs++;
            $display("FAIL clr_recount%0d got flt=%b want %b", k, bus.fault,
                     (k == FL) ? 5'b00100 : 5'b00000);
         end
      end
      tick(1'b0, rnd_din(), 1'b1);
   endtask

`ifdef FAULT_MASK_EN
   din_t tie_pat;

   task automatic test_tie();
      for (int k = 0; k < FL; k++) tick(1'b1, mk(4'h3, 4, 4'h0), 1'b0);
      vectors++;
      if ({bus.fault, bus.dout} !== {5'b10000, 4'h3}) begin
         errs++;
         $display("FAIL tie_setup got flt=%b dout=%h want 10000 3", bus.fault, bus.dout);
      end
      tie_pat = mk(4'h0, -1, 4'h0);
      tie_pat[0] = 4'hF; tie_pat[1] = 4'hF; tie_pat[4] = 4'hC;
      tick(1'b1, tie_pat, 1'b0);
      vectors++;
      if ({bus.dout, bus.tie, bus.disagree, bus.out_valid} !== {4'h3, 1'b1, 5'b01111, 1'b1}) begin
         errs++;
         $display("FAIL tie_vote got dout=%h tie=%b dis=%b ov=%b want 3 1 01111 1",
                  bus.dout, bus.tie, bus.disagree, bus.out_valid);
      end
   endtask

   task automatic test_no_quorum();
      for (int k = 1; k < FL; k++) tick(1'b1, tie_pat, 1'b0);
      vectors++;
      if (bus.fault !== 5'b11111) begin
         errs++;
         $display("FAIL nq_all_faulted got flt=%b want 11111", bus.fault);
      end
      tick(1'b1, rnd_din(), 1'b0);
      vectors++;
      if ({bus.no_quorum, bus.dout, bus.out_valid, bus.disagree} !== {1'b1, 4'h3, 1'b1, 5'b0}) begin
         errs++;
         $display("FAIL nq_vote got nq=%b dout=%h ov=%b dis=%b want 1 3 1 00000",
                  bus.no_quorum, bus.dout, bus.out_valid, bus.disagree);
      end
      tick(1'b0, rnd_din(), 1'b1);
      tick(1'b1, mk(4'hA, 2, 4'h5), 1'b0);
      vectors++;
      if ({bus.no_quorum, bus.dout, bus.disagree, bus.fault} !== {1'b0, 4'hA, 5'b00100, 5'b0}) begin
         errs++;
         $display("FAIL nq_recover got nq=%b dout=%h dis=%b flt=%b want 0 A 00100 00000",
                  bus.no_quorum, bus.dout, bus.disagree, bus.fault);
      end
   endtask
`endif

   task automatic test_random();
      din_t d;
      logic [W-1:0] base;
      int bad;
      bad = N;
      for (int c = 0; c < 400; c++) begin
         if (c % 25 == 0) bad = $urandom_range(0, N);   // N means no stuck channel
         base = W'($urandom);
         for (int i = 0; i < N; i++)
            d[i] = (i == bad || $urandom_range(0, 9) < 2) ? W'($urandom) : base;
         tick($urandom_range(0, 3) != 0, d, $urandom_range(0, 39) == 0);
         vectors++;
         if ({bus.dout, bus.out_valid, bus.disagree, bus.fault, bus.tie, bus.no_quorum} !==
             {m_dout, m_ov, m_dis, m_fault, m_tie, m_nq}) begin
            errs++;
            $display("FAIL random cyc%0d got dout=%h ov=%b dis=%b flt=%b tie=%b nq=%b want dout=%h ov=%b dis=%b flt=%b tie=%b nq=%b",
                     c, bus.dout, bus.out_valid, bus.disagree, bus.fault, bus.tie, bus.no_quorum,
                     m_dout, m_ov, m_dis, m_fault, m_tie, m_nq);
         end
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.din       = '0;
      bus.fault_clr = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_fault();
      test_clr_priority();
`ifdef FAULT_MASK_EN
      test_tie();
      test_no_quorum();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/majority_voter_seq.md
# majority_voter_seq

Registered, parametrised N-channel bitwise majority voter with per-channel fault tracking. Each valid cycle, the block votes N redundant W-bit input words into one output word. It counts consecutive disagreements per channel and raises a sticky fault flag once a channel has disagreed for FAULT_LIMIT valid cycles. It sits at the boundary of redundant (TMR/NMR) logic groups and replaces the fixed three-input combinational majority gate.

## Interface
- N, default 5: channel count; 3..15.
- W, default 4: bits per channel word.
- FAULT_LIMIT, default 4: consecutive disagreeing valid cycles that set a fault; 1..255.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  din is valid this cycle.
- din  input  N*W  channel i occupies bits [i*W +: W].
- fault_clr  input  1  clears all fault flags and counters.
- dout  output  W  voted word, registered.
- out_valid  output  1  dout updated this cycle.
- disagree  output  N  per-channel mismatch against the vote, registered.
- fault  output  N  sticky per-channel fault flags.
- tie  output  1  at least one bit of the current vote tied.
- no_quorum  output  1  no active channels this vote (mask build only).

## Operation
- Active set:
  - All N channels without the configuration macro.
  - With the macro, channels whose fault bit is clear.
  - A = popcount of the active set.
- Vote, per bit b, with ones = number of active channels whose bit b is 1:
  - 2*ones > A gives 1.
  - 2*ones < A gives 0.
  - 2*ones == A holds the previous dout bit and asserts tie.
- Ties occur only when A is even, which is possible only with masking.
- A == 0:
  - dout holds.
  - no_quorum = 1.
  - out_valid still pulses.
  - disagree = 0.
  - Counters unchanged.
- disagree[i] = active[i] AND (channel i word != the new voted word). Comparison is on the whole word.
- Per-channel counter cnt[i], width clog2(FAULT_LIMIT+1), updated only on in_valid cycles:
  - Disagree: cnt[i] increments, saturating at FAULT_LIMIT.
  - Agree: cnt[i] resets to 0.
- fault[i] sets on the edge where cnt[i] reaches FAULT_LIMIT and stays set until fault_clr or rst.
- Cycles with in_valid low:
  - dout, disagree and counters hold.
  - out_valid = 0.
  - tie = 0.
  - no_quorum = 0.
- fault_clr: zeroes all cnt and fault bits on the next edge. It takes priority over a simultaneous increment or fault set; dout and disagree still update normally.

## Timing
- Latency 1: in_valid at edge t produces dout, out_valid, disagree, tie and no_quorum after edge t+1.
- A fault flag is visible in the same cycle as the disagree that completed the count.
- Full throughput: in_valid may be held high continuously. There is no backpressure.
- Reset values: every output 0, every counter 0.
- Reset mid-stream discards the in-flight vote; out_valid = 0 in the cycle after rst.
- Masking changes take effect on the vote after the fault edge, never on the same cycle.

## Configuration
- FAULT_MASK_EN defined:
  - Faulted channels are excluded from the vote and from disagree.
  - Tie and no_quorum logic are built.
- FAULT_MASK_EN undefined:
  - All N channels always vote; faults are report-only.
  - A == N is odd, so tie and no_quorum are tied to 0.

## Structure
- Package majority_pkg holds:
  - popcount function.
  - Counter-width function clog2.
  - Parameter legality checks: N odd, N in 3..15, FAULT_LIMIT >= 1.
- Sub-module majority_fault_ctr holds one channel's saturating counter and sticky flag; the top level instantiates it N times.
- Top level holds the vote, the active mask and the output registers.

## Test plan
All scenarios use N=5, W=4, FAULT_LIMIT=4.
1. Reset with random din and in_valid=1 → every output 0 throughout rst and in the first cycle after its release.
2. All channels 4'hA except ch2 = 4'h5, one valid cycle → next cycle dout=4'hA, out_valid=1, disagree=5'b00100, tie=0.
3. ch2 wrong on 4 consecutive valid cycles, with idle in_valid=0 gaps between them → fault=5'b00100 after the 4th. A second run of 3 mismatches, 1 agreement, then 3 mismatches → fault stays 0.
4. fault_clr asserted on the same cycle as ch2's 4th mismatch → fault=0, counter 0, dout=4'hA.
5. FAULT_MASK_EN, ch4 faulted, prior dout=4'h3; ch0 and ch1 = 4'hF, ch2 and ch3 = 4'h0 → dout=4'h3, tie=1, disagree=5'b01111.
6. FAULT_MASK_EN, all five channels faulted → vote gives no_quorum=1, dout held, out_valid=1. Then fault_clr, and the next vote uses all 5 channels with no_quorum=0.
